uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIVISOR, default 163, meaning clk cycles per oversample tick (50 MHz / (19200 baud x 16)).
REQ-002 SHALL have parameter DBIT, default 8, meaning data bits per frame.
REQ-003 SHALL have parameter SB_TICK, default 16, meaning oversample ticks in the stop bit (16 = 1 stop bit).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: serial line; asynchronous to clk; idle high.
REQ-007 SHALL have port rd, input, 1 bit: consumer read strobe; clears rx_valid.
REQ-008 SHALL have port datos, output, DBIT bits: last received byte, held until overwritten.
REQ-009 SHALL have port rx_valid, output, 1 bit: datos holds an unread byte.
REQ-010 SHALL have port rx_done_tick, output, 1 bit: one-clk pulse when a frame completes.
REQ-011 SHALL have port frame_err, output, 1 bit: last frame's stop bit sampled low.
REQ-012 SHALL have port overrun, output, 1 bit: sticky; a byte arrived while rx_valid=1.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-014 SHALL assert s_tick for exactly one clk when the baud counter equals DIVISOR-1, then wrap the counter to 0; the counter free-runs from reset.
REQ-015 SHALL implement states IDLE, START, DATA, STOP with internal tick counter s_cnt (4 bits) and bit counter n (width of DBIT-1).
REQ-016 In IDLE, SHALL move to START and clear s_cnt when rx_s=0; otherwise remain in IDLE.
REQ-017 In START, on s_tick with s_cnt=7, SHALL re-check rx_s: if 0, move to DATA and clear s_cnt and n; if 1, treat as a glitch and return to IDLE with no output change.
REQ-018 In DATA, on s_tick with s_cnt=15, SHALL shift rx_s into the shift register MSB-first-in so that the byte is assembled LSB first, clear s_cnt, and increment n; after bit n=DBIT-1 SHALL move to STOP.
REQ-019 In STOP, on s_tick with s_cnt=SB_TICK-1, SHALL load datos from the shift register, pulse rx_done_tick, set frame_err to the inverse of rx_s, and return to IDLE.
REQ-020 SHALL increment s_cnt on every s_tick that is not a transition tick in START, DATA and STOP.
REQ-021 SHALL set rx_valid with the rx_done_tick cycle and clear it on the cycle after rd=1; if rd=1 and completion coincide, rx_valid SHALL be 1 (the new byte wins).
REQ-022 SHALL set overrun when a frame completes while rx_valid=1 and rd=0; overrun SHALL clear only on reset; datos SHALL still be overwritten.
REQ-023 SHALL ignore rd when rx_valid=0.
REQ-024 SHALL latch a frame with frame_err=1 into datos and raise rx_valid as for a good frame.
REQ-025 SHALL have a latency from the centre of the stop bit to rx_done_tick of at most 1 clk after the qualifying s_tick.

Reset
REQ-026 On reset_n=0, SHALL asynchronously set the state to IDLE, s_cnt, n, shift register and baud counter to 0, datos to 0, and rx_valid, rx_done_tick, frame_err and overrun to 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no rx_done_tick; after release, reception SHALL resume at the next falling edge of rx_s.

Structure
REQ-028 A shared package uart_pkg SHALL hold the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the defaults for DIVISOR, DBIT and SB_TICK.
REQ-029 The baud tick generator SHALL be a separate sub-module, baud_gen (ports clk, reset_n, s_tick), parameterised by DIVISOR; all other logic SHALL reside in uart_rx.

Verification
REQ-030 With DIVISOR=4, send 0x55 at 16 ticks per bit with a high stop bit: SHALL give datos=0x55, one rx_done_tick, rx_valid=1, frame_err=0.
REQ-031 Send 0xA3 with the stop bit held low: SHALL give datos=0xA3 and frame_err=1.
REQ-032 Pulse rx low for 3 ticks only: SHALL return to IDLE with no rx_done_tick and datos unchanged.
REQ-033 Send 0x12 then 0x34 with no rd: SHALL give datos=0x34 and overrun=1; a following rd SHALL clear rx_valid.
REQ-034 Assert reset_n=0 during DATA bit 4 of 0xFF: SHALL clear all outputs; a following frame 0x0F SHALL be received correctly.
REQ-035 Assert rd in the same cycle as rx_done_tick: SHALL leave rx_valid=1 and overrun unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default
// timing parameters (50 MHz clock, 19200 baud, 16x oversampling, 8N1).
package uart_pkg;

    localparam int DIVISOR_DEF = 163;
    localparam int DBIT_DEF    = 8;
    localparam int SB_TICK_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/baud_gen.sv
// Free-running oversample tick generator: s_tick is high for one clk every
// DIVISOR cycles, on the cycle the counter sits at DIVISOR-1.
module baud_gen
    import uart_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEF
) (
    input  logic clk,
    input  logic reset_n,
    output logic s_tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(DIVISOR - 1));
    assign s_tick = wrap;

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, read handshake, framing-error and
// sticky overrun reporting.
//
//   state | meaning
//   IDLE  | line idle, waiting for rx_s to fall
//   START | counting to the start-bit centre, re-checking for a glitch
//   DATA  | sampling DBIT data bits at their centres, LSB first
//   STOP  | waiting for the stop-bit centre, then delivering the byte
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIVISOR = DIVISOR_DEF,
    parameter int DBIT    = DBIT_DEF,
    parameter int SB_TICK = SB_TICK_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] datos,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic            s_tick;
    logic            rx_meta_q, rx_s_q;
    rx_state_e       state_q, state_d;
    logic [3:0]      s_cnt_q, s_cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] datos_q, datos_d;
    logic            done_q, done_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            complete;

    baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .s_tick  (s_tick)
    );

    always_comb begin
        state_d  = state_q;
        s_cnt_d  = s_cnt_q;
        n_d      = n_q;
        b_d      = b_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd7) begin
                        // A start bit that is high again at its centre was noise.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'd15) begin
                        s_cnt_d = '0;
                        b_d     = {rx_s_q, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == 4'(SB_TICK - 1)) begin
                        state_d  = IDLE;
                        complete = 1'b1;
                    end else begin
                        s_cnt_d = s_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        datos_d = complete ? b_q : datos_q;
        ferr_d  = complete ? ~rx_s_q : ferr_q;
        done_d  = complete;

        // The handshake acts on the delivery cycle, so a read coinciding
        // with rx_done_tick loses to the new byte and does not count as overrun.
        valid_d = done_q ? 1'b1 : (rd ? 1'b0 : valid_q);
        ovr_d   = ovr_q | (done_q & valid_q & ~rd);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            n_q       <= '0;
            b_q       <= '0;
            datos_q   <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            n_q       <= n_d;
            b_q       <= b_d;
            datos_q   <= datos_d;
            done_q    <= done_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign datos        = datos_q;
    assign rx_valid     = valid_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;

endmodule
